// File: rtl/jk_ff_pkg.sv
// Shared types and next-state function for the JK flip-flop bank.
// The {j,k} pair is decoded as a 2-bit operation.
package jk_ff_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    // Pure next-state function for one JK cell.
    function automatic logic jk_next(input jk_op_e op, input logic q);
        logic nxt;
        nxt = q;
        case (op)
            JK_HOLD:   nxt = q;
            JK_RESET:  nxt = 1'b0;
            JK_SET:    nxt = 1'b1;
            JK_TOGGLE: nxt = ~q;
            default:   nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_ff_bit.sv
// Single-bit JK flip-flop cell with asynchronous active-high clear.
// Optional clock enable is present when JK_FF_CE_EN is defined.
module jk_ff_bit
    import jk_ff_pkg::*;
#(
    parameter logic RST_VALUE = 1'b0
) (
    input  logic clk,
    input  logic clear,
`ifdef JK_FF_CE_EN
    input  logic ce,
`endif
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic   q_r;
    jk_op_e op_s;

    assign op_s = jk_op_e'({j, k});

    // State register: clear loads the reset value at once, otherwise apply the JK operation.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q_r <= RST_VALUE;
`ifdef JK_FF_CE_EN
        end else if (ce) begin
            q_r <= jk_next(op_s, q_r);
        end
`else
        end else begin
            q_r <= jk_next(op_s, q_r);
        end
`endif
    end

    assign q     = q_r;
    assign q_bar = ~q_r;

endmodule

// File: rtl/jk_ff.sv
// Bank of WIDTH independent JK flip-flops sharing clk and clear.
// Define JK_FF_CE_EN to add a shared clock-enable input ce.
module jk_ff
    import jk_ff_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RST_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clear,
`ifdef JK_FF_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_bit #(
            .RST_VALUE (RST_VALUE[i])
        ) u_cell (
            .clk   (clk),
            .clear (clear),
`ifdef JK_FF_CE_EN
            .ce    (ce),
`endif
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

endmodule

// File: tb/tb_jk_ff.sv
// Directed self-checking bench for jk_ff: a 1-bit instance and a 4-bit instance.
module tb_jk_ff;

    logic       clk;
    logic       clear1, j1, k1, q1, qb1;
    logic       clear4;
    logic [3:0] j4, k4, q4, qb4;
`ifdef JK_FF_CE_EN
    logic       ce1;
`endif
    int checks = 0;
    int errors = 0;

    jk_ff dut1 (
        .clk   (clk),
        .clear (clear1),
`ifdef JK_FF_CE_EN
        .ce    (ce1),
`endif
        .j     (j1),
        .k     (k1),
        .q     (q1),
        .q_bar (qb1)
    );

    jk_ff #(.WIDTH(4), .RST_VALUE(4'b1010)) dut4 (
        .clk   (clk),
        .clear (clear4),
`ifdef JK_FF_CE_EN
        .ce    (1'b1),
`endif
        .j     (j4),
        .k     (k4),
        .q     (q4),
        .q_bar (qb4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
        clear4 = 1'b1; j4 = 4'b1111; k4 = 4'b0000;
`ifdef JK_FF_CE_EN
        ce1 = 1'b1;
`endif
        // Reset held through the first edge
        step();
        chk("rst_q", {3'b000, q1}, 4'b0000);
        chk("rst_qb", {3'b000, qb1}, 4'b0001);
        chk("rst4_q", q4, 4'b1010);
        chk("rst4_qb", qb4, 4'b0101);

        // Set
        clear1 = 1'b0; j1 = 1'b1; k1 = 1'b0;
        step();
        chk("set_q", {3'b000, q1}, 4'b0001);
        chk("set_qb", {3'b000, qb1}, 4'b0000);

        // Reset via K, then hold for 3 edges
        j1 = 1'b0; k1 = 1'b1;
        step();
        chk("kres_q", {3'b000, q1}, 4'b0000);
        chk("kres_qb", {3'b000, qb1}, 4'b0001);
        k1 = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("hold_q", {3'b000, q1}, 4'b0000);
        end

        // Toggle from 0: 1,0,1,0
        j1 = 1'b1; k1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("tog_q", {3'b000, q1}, (n % 2 == 0) ? 4'b0001 : 4'b0000);
            chk("tog_qb", {3'b000, qb1}, (n % 2 == 0) ? 4'b0000 : 4'b0001);
        end

        // Async clear between edges, then an edge with clear still high
        j1 = 1'b1; k1 = 1'b0;
        step();
        chk("pre_async_q", {3'b000, q1}, 4'b0001);
        #2 clear1 = 1'b1;
        #1;
        chk("async_q", {3'b000, q1}, 4'b0000);
        chk("async_qb", {3'b000, qb1}, 4'b0001);
        step();
        chk("clr_edge_q", {3'b000, q1}, 4'b0000);
        clear1 = 1'b0;
        step();
        chk("post_clr_q", {3'b000, q1}, 4'b0001);

`ifdef JK_FF_CE_EN
        // Clock enable gating
        j1 = 1'b0; k1 = 1'b1;
        step();
        chk("ce_pre_q", {3'b000, q1}, 4'b0000);
        ce1 = 1'b0; j1 = 1'b1; k1 = 1'b0;
        for (int n = 0; n < 2; n++) begin
            step();
            chk("ce_off_q", {3'b000, q1}, 4'b0000);
        end
        ce1 = 1'b1;
        step();
        chk("ce_on_q", {3'b000, q1}, 4'b0001);
`endif

        // 4-bit bank: per-bit independence
        chk("rst4_held_q", q4, 4'b1010);
        clear4 = 1'b0; j4 = 4'b0011; k4 = 4'b1100;
        step();
        chk("jk4_q", q4, 4'b0011);
        chk("jk4_qb", qb4, 4'b1100);
        j4 = 4'b1111; k4 = 4'b1111;
        step();
        chk("tog4_q", q4, 4'b1100);
        chk("tog4_qb", qb4, 4'b0011);
        j4 = 4'b0000; k4 = 4'b0000;
        step();
        chk("hold4_q", q4, 4'b1100);
        j4 = 4'b0101; k4 = 4'b0110;
        step();
        chk("mix4_q", q4, 4'b1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
